// File: rtl/platformniossdram_pio_pkg.sv
// rtl/platformniossdram_pio_pkg.sv - shared constants and edge helper for the keys PIO
package platformniossdram_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Any unknown encoding behaves as EDGE_ANY.
    function automatic logic edge_event(input logic cur, input logic prev, input int edge_type);
        case (edge_type)
            EDGE_RISING:  return cur & ~prev;
            EDGE_FALLING: return ~cur & prev;
            default:      return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/platformniossdram_key_debounce.sv
// rtl/platformniossdram_key_debounce.sv - one-bit synchroniser and debouncer (KEYS_PIO_DEBOUNCE_EN)
module platformniossdram_key_debounce
    import platformniossdram_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
`ifdef KEYS_PIO_DEBOUNCE_EN
    input  logic primed,
`endif
    input  logic din,
    output logic stable
);

    logic meta;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= din;
            sync_q <= meta;
        end
    end

`ifdef KEYS_PIO_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Counter measures how long sync_q has disagreed with stable; any agreement restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!primed) begin
            cnt    <= '0;
            stable <= sync_q;
        end else if (sync_q == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            stable <= sync_q;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
        end else begin
            stable <= sync_q;
        end
    end
`endif

endmodule

// File: rtl/platformniossdram_keys_edge_pio.sv
// rtl/platformniossdram_keys_edge_pio.sv - Avalon-MM key input PIO with edge capture and IRQ (KEYS_PIO_DEBOUNCE_EN)
module platformniossdram_keys_edge_pio
    import platformniossdram_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [31:0]      rd_mux;
    logic             wr;

    wire unused_wd = &{1'b0, writedata};

`ifdef KEYS_PIO_DEBOUNCE_EN
    logic primed;

    always_ff @(posedge clk) begin
        if (reset) begin
            primed <= 1'b0;
        end else begin
            primed <= 1'b1;
        end
    end
`endif

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_key
        platformniossdram_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk    (clk),
            .reset  (reset),
`ifdef KEYS_PIO_DEBOUNCE_EN
            .primed (primed),
`endif
            .din    (in_port[gi]),
            .stable (stable[gi])
        );
    end

    always_comb begin
        evt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            evt[i] = edge_event(stable[i], stable_d[i], EDGE_TYPE);
        end
    end

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecapture;
            default:      rd_mux = '0;
        endcase
    end

    // An event arriving with its own clear keeps the bit set so no edge is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d    <= '0;
            edgecapture <= '0;
            irqmask     <= '0;
            irq         <= 1'b0;
            readdata    <= '0;
        end else begin
            stable_d    <= stable;
            edgecapture <= evt | (edgecapture & ~clr);
            if (wr && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            irq      <= |(edgecapture & irqmask);
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_platformniossdram_keys_edge_pio.sv
// tb/tb_platformniossdram_keys_edge_pio.sv - randomized model-checked bench for the keys PIO
module tb_platformniossdram_keys_edge_pio;

    localparam int W  = 4;
    localparam int ET = 1;
    localparam int DB = 4;
`ifdef KEYS_PIO_DEBOUNCE_EN
    localparam int EFF_D = DB;
`else
    localparam int EFF_D = 1;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int n_tests;
    int n_fail;

    platformniossdram_keys_edge_pio #(
        .WIDTH(W), .EDGE_TYPE(ET), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: keys accepted after EFF_D consecutive disagreeing synchronised samples.
    logic [W-1:0] m_p1, m_p2, m_stable, m_mask, m_ec, m_pend;
    logic         m_primed;
    logic [31:0]  m_rd;
    logic         m_irq;
    logic [W-1:0] hist[$];

    function automatic void model_step();
        logic [W-1:0] acc;
        logic [W-1:0] clr;
        logic         all_diff;
        if (reset) begin
            m_p1 = '0; m_p2 = '0; m_stable = '0; m_mask = '0; m_ec = '0; m_pend = '0;
            m_primed = 1'b0; m_rd = '0; m_irq = 1'b0;
            hist.delete();
            return;
        end
        case (address)
            2'd0:    m_rd = {28'd0, m_stable};
            2'd2:    m_rd = {28'd0, m_mask};
            2'd3:    m_rd = {28'd0, m_ec};
            default: m_rd = '0;
        endcase
        m_irq = |(m_ec & m_mask);
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        m_ec = (m_ec & ~clr) | m_pend;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        acc = '0;
        if (!m_primed) begin
            m_stable = m_p2;
            m_primed = 1'b1;
        end else begin
            hist.push_back(m_p2);
            if (hist.size() > EFF_D) void'(hist.pop_front());
            if (hist.size() == EFF_D) begin
                for (int i = 0; i < W; i++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < EFF_D; k++)
                        if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
                    acc[i] = all_diff;
                end
            end
            m_stable = m_stable ^ acc;
        end
        case (ET)
            0:       m_pend = acc & m_stable;
            1:       m_pend = acc & ~m_stable;
            default: m_pend = acc;
        endcase
        m_p2 = m_p1;
        m_p1 = in_port;
    endfunction

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        expect_eq("readdata", readdata, m_rd);
        expect_eq("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    initial begin
        #200us;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 4'hF;

        // 1: reset with idle-high keys
        ticks(3);
        expect_eq("rst_rd", readdata, 32'h0);
        expect_eq("rst_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;
        ticks(10);
        expect_eq("idle_data", readdata, 32'h0000000F);
        address = 2'd3;
        ticks(2);
        expect_eq("idle_ec", readdata, 32'h0);

        // 2: falling edge on bit 2 with it unmasked
        reg_write(2'd2, 32'h4);
        address = 2'd3;
        in_port = 4'hB;
        ticks(12);
        expect_eq("fall_ec", readdata, 32'h4);
        expect_eq("fall_irq", {31'd0, irq}, 32'h1);

        // 3: 3-cycle low glitch on bit 1
        reg_write(2'd3, 32'h4);
        address = 2'd3;
        in_port = 4'h9;
        ticks(3);
        in_port = 4'hB;
        ticks(10);
        expect_eq("glitch_ec", readdata, (EFF_D > 3) ? 32'h0 : 32'h2);

        // 4: clear coincident with a new event on bit 2
        reg_write(2'd3, 32'hF);
        address = 2'd3;
        in_port = 4'hF; ticks(12);
        in_port = 4'hB; ticks(12);
        in_port = 4'hF; ticks(12);
        in_port = 4'hB;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = m_pend[2];
        end
        expect_eq("evt_seen", {31'd0, found}, 32'h1);
        reg_write(2'd3, 32'h4);
        address = 2'd3;
        tick();
        expect_eq("race_ec", readdata, 32'h4);
        expect_eq("race_irq", {31'd0, irq}, 32'h1);
        reg_write(2'd3, 32'h4);
        address = 2'd3;
        tick();
        expect_eq("clr_ec", readdata, 32'h0);
        expect_eq("clr_irq", {31'd0, irq}, 32'h0);

        // 5: masked event, then unmask
        reg_write(2'd2, 32'h0);
        address = 2'd3;
        in_port = 4'hA;
        ticks(12);
        expect_eq("mask_ec", readdata, 32'h1);
        expect_eq("mask_irq", {31'd0, irq}, 32'h0);
        reg_write(2'd2, 32'h1);
        tick();
        expect_eq("unmask_irq", {31'd0, irq}, 32'h1);

        // 6: reset during a partial debounce count
        in_port = 4'hF; ticks(12);
        reg_write(2'd3, 32'hF);
        address = 2'd3;
        in_port = 4'h7;
        ticks(3);
        reset = 1'b1;
        ticks(2);
        expect_eq("mid_rst_rd", readdata, 32'h0);
        expect_eq("mid_rst_irq", {31'd0, irq}, 32'h0);
        reset = 1'b0;
        ticks(12);
        expect_eq("post_rst_ec", readdata, 32'h0);

        // single-cycle pulse on bit 3: captured only when debounce is absent
        in_port = 4'hF; ticks(6);
        reg_write(2'd3, 32'hF);
        address = 2'd3;
        in_port = 4'h7; tick();
        in_port = 4'hF; ticks(8);
        expect_eq("pulse_ec", readdata, (EFF_D == 1) ? 32'h8 : 32'h0);

        // randomized traffic against the model
        for (int c = 0; c < 500; c++) begin
            reset = ($urandom_range(199) == 0);
            if ($urandom_range(5) == 0) in_port = in_port ^ 4'($urandom);
            address    = 2'($urandom);
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(3) != 0);
            writedata  = $urandom;
            tick();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
